// File: rtl/sdram_pkg.sv
// sdram_pkg: command/state encodings and default address widths shared by the arbiter and the SDRAM command engine
package sdram_pkg;
  typedef enum logic [1:0] {CMD_NONE = 2'b00, CMD_REF = 2'b01, CMD_WR = 2'b10, CMD_RD = 2'b11} cmd_t;
  typedef enum logic [2:0] {S_INIT, S_IDLE, S_REF, S_WR, S_RD} state_t;
  localparam int BANK_W_DEF = 2;
  localparam int ROW_W_DEF  = 12;
  localparam int COL_W_DEF  = 8;
endpackage

// File: rtl/sdram_req_arb_if.sv
// sdram_req_arb_if: request/command bundle between users, the arbiter and the command engine
//   master: user/engine side (drives wr/rd requests, addresses, cmd_done)
//   slave : arbiter side (drives acks, cmd_* stream, busy, ref_err)
interface sdram_req_arb_if import sdram_pkg::*; #(
  parameter int BANK_W = BANK_W_DEF,
  parameter int ROW_W  = ROW_W_DEF,
  parameter int COL_W  = COL_W_DEF
);
  logic                          wr_req, wr_ack, rd_req, rd_ack;
  logic [BANK_W+ROW_W+COL_W-1:0] wr_addr, rd_addr;
  logic                          cmd_vld, cmd_done, busy, ref_err;
  cmd_t                          cmd_type;
  logic [BANK_W-1:0]             cmd_bank;
  logic [ROW_W-1:0]              cmd_row;
  logic [COL_W-1:0]              cmd_col;
  modport master (
    output wr_req, wr_addr, rd_req, rd_addr, cmd_done,
    input  wr_ack, rd_ack, cmd_vld, cmd_type, cmd_bank, cmd_row, cmd_col, busy, ref_err
  );
  modport slave (
    input  wr_req, wr_addr, rd_req, rd_addr, cmd_done,
    output wr_ack, rd_ack, cmd_vld, cmd_type, cmd_bank, cmd_row, cmd_col, busy, ref_err
  );
endinterface

// File: rtl/sdram_ref_timer.sv
// sdram_ref_timer: auto-refresh interval timer
//   init_done: timer runs only while high; low clears timer and ref_pend
//   ref_clr  : refresh granted this cycle (terminal count still wins)
//   ref_pend : refresh owed; ref_err: sticky, a period expired with refresh still owed
module sdram_ref_timer #(
  parameter int REF_PERIOD = 780
) (
  input  logic clk,
  input  logic rst_n,
  input  logic init_done,
  input  logic ref_clr,
  output logic ref_pend,
  output logic ref_err
);
  localparam int TW = $clog2(REF_PERIOD);
  logic [TW-1:0] timer_q, timer_d;
  logic          pend_q, pend_d, err_q, err_d, tc;
  always_comb begin
    tc      = init_done && timer_q == TW'(REF_PERIOD - 1);
    timer_d = (!init_done || tc) ? '0 : timer_q + TW'(1);
    pend_d  = !init_done ? 1'b0 : tc ? 1'b1 : ref_clr ? 1'b0 : pend_q;
    err_d   = err_q || (tc && pend_q && !ref_clr);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      timer_q <= '0;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      timer_q <= timer_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
    end
  assign ref_pend = pend_q;
  assign ref_err  = err_q;
endmodule

// File: rtl/sdram_req_arb.sv
// sdram_req_arb: arbitrates refresh, write-burst and read-burst requests into one outstanding SDRAM command
//   clk, rst_n (async active-low), init_done (level), bus (sdram_req_arb_if.slave)
//   Refresh always wins; SDRAM_ARB_RR_EN selects write/read round-robin, otherwise write beats read.
module sdram_req_arb import sdram_pkg::*; #(
  parameter int REF_PERIOD = 780,
  parameter int BANK_W     = BANK_W_DEF,
  parameter int ROW_W      = ROW_W_DEF,
  parameter int COL_W      = COL_W_DEF
) (
  input logic            clk,
  input logic            rst_n,
  input logic            init_done,
  sdram_req_arb_if.slave bus
);
  localparam int AW = BANK_W + ROW_W + COL_W;
  state_t          state_q, state_d;
  cmd_t            type_q, type_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            vld_q, vld_d, wa_q, wa_d, ra_q, ra_d;
  logic            go, ref_g, wr_g, rd_g, ref_pend;
`ifdef SDRAM_ARB_RR_EN
  logic            last_wr_q, last_wr_d;
`endif
  always_comb begin
    go      = init_done && state_q == S_IDLE;
    ref_g   = go && ref_pend;
`ifdef SDRAM_ARB_RR_EN
    wr_g    = go && !ref_pend && bus.wr_req && !(bus.rd_req && last_wr_q);
`else
    wr_g    = go && !ref_pend && bus.wr_req;
`endif
    rd_g    = go && !ref_pend && bus.rd_req && !wr_g;
    // cmd_done only matters in a command state; in S_IDLE the fallback keeps S_IDLE anyway
    state_d = !init_done ? S_INIT : ref_g ? S_REF : wr_g ? S_WR : rd_g ? S_RD :
              (state_q == S_INIT || bus.cmd_done) ? S_IDLE : state_q;
    type_d  = !init_done ? CMD_NONE : ref_g ? CMD_REF : wr_g ? CMD_WR : rd_g ? CMD_RD : type_q;
    addr_d  = (!init_done || ref_g) ? '0 : wr_g ? bus.wr_addr : rd_g ? bus.rd_addr : addr_q;
    vld_d   = ref_g || wr_g || rd_g;
    wa_d    = wr_g;
    ra_d    = rd_g;
`ifdef SDRAM_ARB_RR_EN
    last_wr_d = wr_g || (last_wr_q && !rd_g);
`endif
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_INIT;
      type_q  <= CMD_NONE;
      addr_q  <= '0;
      vld_q   <= 1'b0;
      wa_q    <= 1'b0;
      ra_q    <= 1'b0;
`ifdef SDRAM_ARB_RR_EN
      last_wr_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      addr_q  <= addr_d;
      vld_q   <= vld_d;
      wa_q    <= wa_d;
      ra_q    <= ra_d;
`ifdef SDRAM_ARB_RR_EN
      last_wr_q <= last_wr_d;
`endif
    end
  sdram_ref_timer #(.REF_PERIOD(REF_PERIOD)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_done (init_done),
    .ref_clr   (ref_g),
    .ref_pend  (ref_pend),
    .ref_err   (bus.ref_err)
  );
  assign bus.cmd_vld  = vld_q;
  assign bus.wr_ack   = wa_q;
  assign bus.rd_ack   = ra_q;
  assign bus.cmd_type = type_q;
  assign bus.cmd_bank = addr_q[AW-1 -: BANK_W];
  assign bus.cmd_row  = addr_q[COL_W +: ROW_W];
  assign bus.cmd_col  = addr_q[COL_W-1:0];
  assign bus.busy     = state_q != S_IDLE;
endmodule

// File: tb/tb_sdram_req_arb.sv
// tb_sdram_req_arb: directed + randomized check of sdram_req_arb against a behavioural model
module tb_sdram_req_arb;
  import sdram_pkg::*;
  localparam int RP = 60;
`ifdef SDRAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, init_done = 1'b0;
  always #5 clk = ~clk;
  sdram_req_arb_if bus();
  sdram_req_arb #(.REF_PERIOD(RP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_done (init_done),
    .bus       (bus.slave)
  );
  int n_chk = 0, n_fail = 0;
  // model: phase 0=init 1=idle 2=command outstanding; age = clocks with init_done high
  int         m_phase, m_age;
  bit         m_pend, m_err, m_lastwr, e_vld, e_wa, e_ra;
  logic [1:0] e_type;
  logic [21:0] e_addr;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model_clear();
    m_phase = 0; m_age = 0; m_pend = 0;
    e_vld = 0; e_wa = 0; e_ra = 0; e_type = 2'd0; e_addr = '0;
  endtask
  task automatic model_step();
    int g;
    bit tc;
    if (!rst_n) begin
      model_clear();
      m_err = 0;
      m_lastwr = 0;
    end else if (!init_done) model_clear();
    else begin
      g = 0;
      if (m_phase == 1) begin
        if (m_pend) g = 1;
        else if (bus.wr_req && (!bus.rd_req || !RR || !m_lastwr)) g = 2;
        else if (bus.rd_req) g = 3;
      end
      m_age++;
      tc = (m_age % RP) == 0;
      if (tc && m_pend && g != 1) m_err = 1;
      if (tc) m_pend = 1;
      else if (g == 1) m_pend = 0;
      if (m_phase == 0 || (m_phase == 2 && bus.cmd_done)) m_phase = 1;
      if (g != 0) begin
        m_phase = 2;
        e_type = 2'(g);
        e_addr = g == 2 ? bus.wr_addr : g == 3 ? bus.rd_addr : 22'd0;
      end
      if (g == 2) m_lastwr = 1;
      if (g == 3) m_lastwr = 0;
      e_vld = g != 0;
      e_wa = g == 2;
      e_ra = g == 3;
    end
  endtask
  task automatic cyc();
    model_step();
    @(posedge clk);
    @(negedge clk);
    chk("cmd_vld", bus.cmd_vld, e_vld);
    chk("wr_ack", bus.wr_ack, e_wa);
    chk("rd_ack", bus.rd_ack, e_ra);
    chk("cmd_type", bus.cmd_type, e_type);
    chk("cmd_bank", bus.cmd_bank, e_addr[21:20]);
    chk("cmd_row", bus.cmd_row, e_addr[19:8]);
    chk("cmd_col", bus.cmd_col, e_addr[7:0]);
    chk("busy", bus.busy, m_phase != 1);
    chk("ref_err", bus.ref_err, m_err);
  endtask
  task automatic serve(input int n);
    repeat (n) cyc();
    bus.cmd_done = 1'b1;
    cyc();
    bus.cmd_done = 1'b0;
  endtask
  task automatic wait_vld(input int lim, output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!bus.cmd_vld && n < lim);
    chk("wait_vld_timeout", bus.cmd_vld, 1);
  endtask
  initial begin
    int n;
    logic [1:0] exp_t;
    bus.wr_req = 1'b0; bus.rd_req = 1'b0; bus.cmd_done = 1'b0;
    bus.wr_addr = '0; bus.rd_addr = '0;
    repeat (3) cyc();
    chk("rst_busy", bus.busy, 1);
    rst_n = 1'b1;
    repeat (5) cyc();
    chk("init_busy", bus.busy, 1);
    // refresh timing after init
    init_done = 1'b1;
    cyc();
    chk("busy_fall", bus.busy, 0);
    chk("no_vld", bus.cmd_vld, 0);
    wait_vld(100, n);
    chk("ref_latency", n, RP);
    chk("ref_type", bus.cmd_type, CMD_REF);
    repeat (4) cyc();
    chk("busy_held", bus.busy, 1);
    bus.cmd_done = 1'b1;
    cyc();
    bus.cmd_done = 1'b0;
    chk("busy_after_done", bus.busy, 0);
    // single write grant
    bus.wr_req = 1'b1;
    bus.wr_addr = {2'd1, 12'h0A5, 8'h3C};
    cyc();
    chk("wr_ack", bus.wr_ack, 1);
    chk("wr_vld", bus.cmd_vld, 1);
    chk("wr_type", bus.cmd_type, CMD_WR);
    chk("wr_bank", bus.cmd_bank, 1);
    chk("wr_row", bus.cmd_row, 12'h0A5);
    chk("wr_col", bus.cmd_col, 8'h3C);
    chk("wr_no_rd_ack", bus.rd_ack, 0);
    bus.wr_req = 1'b0;
    serve(2);
    // write and read held together
    bus.wr_req = 1'b1; bus.rd_req = 1'b1;
    bus.wr_addr = 22'($urandom); bus.rd_addr = 22'($urandom);
    for (int g = 0; g < 4; g++) begin
      wait_vld(10, n);
      exp_t = (RR && g % 2 == 1) ? CMD_RD : CMD_WR;
      chk("both_req_order", bus.cmd_type, exp_t);
      serve(1);
    end
    bus.wr_req = 1'b0; bus.rd_req = 1'b0;
    // refresh pending and write in the same idle cycle
    repeat (RP - (m_age % RP)) cyc();
    bus.wr_req = 1'b1;
    bus.wr_addr = 22'($urandom);
    cyc();
    chk("ref_first", bus.cmd_type, CMD_REF);
    chk("wr_held_off", bus.wr_ack, 0);
    serve(2);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!bus.wr_ack && n < 10);
    chk("wr_cycles_after_done", n + 1, 2);
    bus.wr_req = 1'b0;
    serve(1);
    // command held across two refresh periods
    bus.rd_req = 1'b1;
    bus.rd_addr = 22'($urandom);
    cyc();
    chk("rd_ack", bus.rd_ack, 1);
    bus.rd_req = 1'b0;
    chk("ref_err_before", bus.ref_err, 0);
    repeat (2 * RP) cyc();
    chk("ref_err_set", bus.ref_err, 1);
    serve(0);
    wait_vld(10, n);
    chk("ref_after_err", bus.cmd_type, CMD_REF);
    serve(1);
    chk("ref_err_sticky", bus.ref_err, 1);
    wait_vld(RP + 10, n);
    serve(1);
    chk("ref_err_sticky2", bus.ref_err, 1);
    // async reset during a write
    bus.wr_req = 1'b1;
    cyc();
    bus.wr_req = 1'b0;
    cyc();
    rst_n = 1'b0;
    cyc();
    chk("rst_busy_mid", bus.busy, 1);
    chk("rst_type", bus.cmd_type, CMD_NONE);
    chk("rst_ref_err", bus.ref_err, 0);
    rst_n = 1'b1;
    cyc();
    // init_done dropped during a read
    bus.rd_req = 1'b1;
    bus.rd_addr = 22'($urandom);
    cyc();
    bus.rd_req = 1'b0;
    cyc();
    init_done = 1'b0;
    cyc();
    chk("init_drop_busy", bus.busy, 1);
    chk("init_drop_type", bus.cmd_type, CMD_NONE);
    chk("init_drop_bank", bus.cmd_bank, 0);
    bus.wr_req = 1'b1; bus.rd_req = 1'b1;
    repeat (5) begin
      cyc();
      chk("init_low_no_wr", bus.wr_ack, 0);
      chk("init_low_no_rd", bus.rd_ack, 0);
    end
    init_done = 1'b1;
    cyc();
    wait_vld(5, n);
    bus.wr_req = 1'b0; bus.rd_req = 1'b0;
    serve(1);
    // randomized traffic
    repeat (1500) begin
      bus.wr_req = $urandom_range(0, 2) != 0;
      bus.rd_req = $urandom_range(0, 2) != 0;
      bus.wr_addr = 22'($urandom);
      bus.rd_addr = 22'($urandom);
      bus.cmd_done = $urandom_range(0, 3) == 0;
      init_done = $urandom_range(0, 199) != 0;
      cyc();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
